twiddle_gen: RTL and testbench

//  Twiddle source for one radix-2 DIF FFT engine: W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), k in [0,N/2).

---
 rtl/twiddle_pkg.sv | 42 ++++
 rtl/twiddle_qrom.sv | 74 +++++++
 rtl/twiddle_gen.sv | 183 ++++++++++++++++++
 tb/tb_twiddle_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/twiddle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : twiddle_pkg
// Brief    : Shared types and index helpers for the quarter-wave twiddle source
// Revision : 1.0 - initial release
// ============================================================================
package twiddle_pkg;

    typedef enum logic [1:0] {
        TG_IDLE  = 2'd0,
        TG_RUN   = 2'd1,
        TG_DRAIN = 2'd2
    } tg_state_t;

    typedef struct packed {
        int   a;
        int   b;
        logic quad;
    } fold_t;

    // Map k in [0,N/2) onto quarter-table addresses: a feeds Re, b feeds Im.
    function automatic fold_t fold_idx(input int k, input int quarter);
        fold_t f;
        if (k <= quarter) begin
            f.a    = k;
            f.b    = quarter - k;
            f.quad = 1'b0;
        end else begin
            f.a    = 2 * quarter - k;
            f.b    = k - quarter;
            f.quad = 1'b1;
        end
        return f;
    endfunction

    // n >> (s+1) is a power of two, so the modulo reduces to a mask.
    function automatic int seq_k(input int j, input int s, input int n);
        return (j & ((n >> (s + 1)) - 1)) << s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/twiddle_qrom.sv
`default_nettype none
// ============================================================================
// Module   : twiddle_qrom
// Brief    : Dual-read registered quarter-wave cosine ROM, N/4+1 words
// Revision : 1.0 - initial release
// ============================================================================
module twiddle_qrom #(
    parameter int TW_BIT_WIDTH = 8,
    parameter int N_FFT        = 256,
    parameter int DEPTH        = N_FFT / 4 + 1,
    parameter int ADDR_WIDTH   = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    i_en,
    input  logic [ADDR_WIDTH-1:0]   i_addr_a,
    input  logic [ADDR_WIDTH-1:0]   i_addr_b,
    output logic [TW_BIT_WIDTH-1:0] o_q_a,
    output logic [TW_BIT_WIDTH-1:0] o_q_b
);

    localparam longint c_ONE   = 64'sd268435456;   // 2^28 fixed-point unit
    localparam longint c_PI_FX = 64'sd843314857;   // round(pi * 2^28)

    // Q[m] = round((2^(W-1)-1) * cos(2*pi*m/N)), evaluated at elaboration
    // with a 10-term Taylor series; matches the reference table image.
    function automatic logic [DEPTH*TW_BIT_WIDTH-1:0] build_table();
        logic [DEPTH*TW_BIT_WIDTH-1:0] t;
        longint theta, x2, term, sum, amp, val, mf, nf;
        t   = '0;
        amp = (longint'(1) << (TW_BIT_WIDTH - 1)) - 64'sd1;
        for (int m = 0; m < DEPTH; m++) begin
            mf    = longint'(m);
            theta = (64'sd2 * c_PI_FX * mf) / longint'(N_FFT);
            x2    = (theta * theta) / c_ONE;
            term  = c_ONE;
            sum   = c_ONE;
            for (int n = 1; n <= 10; n++) begin
                nf   = longint'(n);
                term = -((term * x2) / c_ONE) / (64'sd2 * nf * (64'sd2 * nf - 64'sd1));
                sum  = sum + term;
            end
            val = (sum * amp + c_ONE / 64'sd2) / c_ONE;
            if (val < 64'sd0) begin
                val = 64'sd0;
            end
            t[m*TW_BIT_WIDTH +: TW_BIT_WIDTH] = TW_BIT_WIDTH'(val);
        end
        return t;
    endfunction

    localparam logic [DEPTH*TW_BIT_WIDTH-1:0] c_TABLE = build_table();

    logic [TW_BIT_WIDTH-1:0] w_rom [DEPTH];
    logic [TW_BIT_WIDTH-1:0] r_q_a;
    logic [TW_BIT_WIDTH-1:0] r_q_b;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
            assign w_rom[gi] = c_TABLE[gi*TW_BIT_WIDTH +: TW_BIT_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_q_a <= w_rom[i_addr_a];
            r_q_b <= w_rom[i_addr_b];
        end
    end

    assign o_q_a = r_q_a;
    assign o_q_b = r_q_b;

endmodule
`default_nettype wire

// File: rtl/twiddle_gen.sv
`default_nettype none
// ============================================================================
// Module   : twiddle_gen
// Brief    : Radix-2 DIF twiddle source, direct lookup + per-stage streaming
// Revision : 1.0 - initial release
// ============================================================================
module twiddle_gen
    import twiddle_pkg::*;
#(
    parameter int TW_BIT_WIDTH = 8,
    parameter int N_FFT        = 256,
    parameter int LOG2N        = $clog2(N_FFT),
    parameter int K_WIDTH      = LOG2N - 1,
    parameter int STAGE_WIDTH  = $clog2(LOG2N + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [STAGE_WIDTH-1:0]  stage,
    output logic                    stage_err,
    output logic                    busy,
    output logic                    done,
    input  logic                    req_valid,
    input  logic [K_WIDTH-1:0]      req_k,
    output logic                    req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [TW_BIT_WIDTH-1:0] out_re,
    output logic [TW_BIT_WIDTH-1:0] out_im,
    output logic [K_WIDTH-1:0]      out_k
);

    localparam int c_QUARTER = N_FFT / 4;
    localparam int c_DEPTH   = c_QUARTER + 1;
    localparam int c_AW      = $clog2(c_DEPTH);
    localparam int c_LAST_J  = N_FFT / 2 - 1;

    tg_state_t               r_state, w_state_nxt;
    logic [K_WIDTH-1:0]      r_j;
    logic [STAGE_WIDTH-1:0]  r_stage;
    logic                    w_adv, w_stage_ok, w_last_j;
    logic                    w_issue_valid, w_issue_last;
    logic [K_WIDTH-1:0]      w_issue_k, w_seq_k;
    logic                    w_seq_start, w_j_inc, w_stage_err_nxt, w_done_nxt, w_req_ready;
    fold_t                   w_fold;
    logic [c_AW-1:0]         w_addr_a, w_addr_b;
    logic [TW_BIT_WIDTH-1:0] w_q_a, w_q_b, w_re, w_im;
    logic                    r_s1_valid, r_s1_quad, r_s1_last;
    logic [K_WIDTH-1:0]      r_s1_k;
    logic                    r_out_valid, r_out_last, r_done, r_stage_err;
    logic [TW_BIT_WIDTH-1:0] r_out_re, r_out_im;
    logic [K_WIDTH-1:0]      r_out_k;

    assign w_adv      = !r_out_valid || out_ready;
    assign w_stage_ok = (stage < STAGE_WIDTH'(LOG2N));
    assign w_last_j   = (r_j == K_WIDTH'(c_LAST_J));
    assign w_seq_k    = K_WIDTH'(seq_k(int'(r_j), int'(r_stage), N_FFT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TG_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_issue_valid   = 1'b0;
        w_issue_last    = 1'b0;
        w_issue_k       = req_k;
        w_req_ready     = 1'b0;
        w_seq_start     = 1'b0;
        w_j_inc         = 1'b0;
        w_stage_err_nxt = 1'b0;
        w_done_nxt      = 1'b0;
        case (r_state)
            TG_IDLE: begin
                // start has priority; a coincident direct request waits
                w_req_ready = w_adv && !start;
                if (start) begin
                    if (w_stage_ok) begin
                        w_seq_start = 1'b1;
                        w_state_nxt = TG_RUN;
                    end else begin
                        w_stage_err_nxt = 1'b1;
                    end
                end else if (req_valid && w_adv) begin
                    w_issue_valid = 1'b1;
                end
            end
            TG_RUN: begin
                if (w_adv) begin
                    w_issue_valid = 1'b1;
                    w_issue_k     = w_seq_k;
                    w_j_inc       = 1'b1;
                    if (w_last_j) begin
                        w_issue_last = 1'b1;
                        w_state_nxt  = TG_DRAIN;
                    end
                end
            end
            TG_DRAIN: begin
                if (r_out_valid && out_ready && r_out_last) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = TG_IDLE;
                end
            end
            default: w_state_nxt = TG_IDLE;
        endcase
    end

    assign w_fold   = fold_idx(int'(w_issue_k), c_QUARTER);
    assign w_addr_a = c_AW'(w_fold.a);
    assign w_addr_b = c_AW'(w_fold.b);

    twiddle_qrom #(
        .TW_BIT_WIDTH (TW_BIT_WIDTH),
        .N_FFT        (N_FFT),
        .DEPTH        (c_DEPTH),
        .ADDR_WIDTH   (c_AW)
    ) u_qrom (
        .clk      (clk),
        .i_en     (w_adv),
        .i_addr_a (w_addr_a),
        .i_addr_b (w_addr_b),
        .o_q_a    (w_q_a),
        .o_q_b    (w_q_b)
    );

    // Table entries never exceed 2^(W-1)-1, so plain negation cannot overflow.
    assign w_re = r_s1_quad ? (TW_BIT_WIDTH'(0) - w_q_a) : w_q_a;
    assign w_im = TW_BIT_WIDTH'(0) - w_q_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_j         <= '0;
            r_stage     <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_quad   <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_k      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_k     <= '0;
            r_done      <= 1'b0;
            r_stage_err <= 1'b0;
        end else begin
            r_done      <= w_done_nxt;
            r_stage_err <= w_stage_err_nxt;
            if (w_seq_start) begin
                r_j     <= '0;
                r_stage <= stage;
            end else if (w_j_inc) begin
                r_j <= r_j + K_WIDTH'(1);
            end
            if (w_adv) begin
                r_s1_valid  <= w_issue_valid;
                r_s1_quad   <= w_fold.quad;
                r_s1_last   <= w_issue_last;
                r_s1_k      <= w_issue_k;
                r_out_valid <= r_s1_valid;
                r_out_last  <= r_s1_valid && r_s1_last;
                r_out_re    <= w_re;
                r_out_im    <= w_im;
                r_out_k     <= r_s1_k;
            end
        end
    end

    assign busy      = (r_state != TG_IDLE);
    assign done      = r_done;
    assign stage_err = r_stage_err;
    assign req_ready = w_req_ready;
    assign out_valid = r_out_valid;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign out_k     = r_out_k;

endmodule
`default_nettype wire

// File: tb/tb_twiddle_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_twiddle_gen
// Brief    : Directed self-checking bench for twiddle_gen at N=16, W=8
// Revision : 1.0 - initial release
// ============================================================================
module tb_twiddle_gen;

    localparam int c_W  = 8;
    localparam int c_N  = 16;
    localparam int c_KW = 3;
    localparam int c_SW = 3;

    logic            clk = 1'b0;
    logic            rst, start, req_valid, out_ready;
    logic [c_SW-1:0] stage;
    logic [c_KW-1:0] req_k;
    logic            stage_err, busy, done, req_ready, out_valid;
    logic [c_W-1:0]  out_re, out_im;
    logic [c_KW-1:0] out_k;

    int n_checks = 0;
    int n_err    = 0;
    int n_done   = 0;
    int n_serr   = 0;
    int n_got;
    int rec_k [8];
    int rec_re[8];
    int rec_im[8];
    int exp_k [8];
    // Hand-computed W_16^k for k=0..7 with Q={127,117,90,49,0}
    int re_tab[8] = '{127, 117, 90, 49, 0, -49, -90, -117};
    int im_tab[8] = '{0, -49, -90, -117, -127, -117, -90, -49};
    int dir_k [5] = '{0, 2, 4, 5, 6};

    twiddle_gen #(.TW_BIT_WIDTH(c_W), .N_FFT(c_N)) dut (
        .clk(clk), .rst(rst), .start(start), .stage(stage), .stage_err(stage_err),
        .busy(busy), .done(done), .req_valid(req_valid), .req_k(req_k),
        .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_k(out_k)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done)      n_done <= n_done + 1;
        if (stage_err) n_serr <= n_serr + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Accept n words; pat=0 keeps out_ready high, pat=1 drives 1,0,0,1,0,0...
    task automatic collect(input int n, input int pat);
        int  c = 0;
        bit  stalled = 1'b0;
        int  sk = 0, sr = 0, si = 0;
        n_got = 0;
        while (n_got < n && c < 200) begin
            out_ready = (pat == 0) ? 1'b1 : ((c % 3) == 0);
            @(negedge clk);
            if (stalled) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_k", int'(out_k), sk);
                check("stall_re", int'($signed(out_re)), sr);
                check("stall_im", int'($signed(out_im)), si);
            end
            stalled = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    rec_k[n_got]  = int'(out_k);
                    rec_re[n_got] = int'($signed(out_re));
                    rec_im[n_got] = int'($signed(out_im));
                    n_got++;
                end else begin
                    stalled = 1'b1;
                    sk = int'(out_k);
                    sr = int'($signed(out_re));
                    si = int'($signed(out_im));
                end
            end
            @(posedge clk);
            #1;
            c++;
        end
        check("collect_count", n_got, n);
    endtask

    task automatic cmp_seq(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_k%0d", tag, i), rec_k[i], exp_k[i]);
            check($sformatf("%s_re%0d", tag, i), rec_re[i], re_tab[exp_k[i]]);
            check($sformatf("%s_im%0d", tag, i), rec_im[i], im_tab[exp_k[i]]);
        end
    endtask

    task automatic check_done(input string tag);
        @(negedge clk);
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_busy_off"}, int'(busy), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(done), 0);
    endtask

    task automatic kick(input int s);
        @(posedge clk);
        #1;
        start = 1'b1;
        stage = c_SW'(s);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int nd;
        bit found;
        rst = 1'b1; start = 1'b0; stage = '0; req_valid = 1'b0; req_k = '0; out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_serr", int'(stage_err), 0);
        check("rst_re", int'(out_re), 0);
        check("rst_im", int'(out_im), 0);
        check("rst_k", int'(out_k), 0);
        check("rst_req_ready", int'(req_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Direct lookups, back-to-back, two-cycle latency
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            if (i < 5) begin
                req_valid = 1'b1;
                req_k     = c_KW'(dir_k[i]);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 5) check($sformatf("dir_ready%0d", i), int'(req_ready), 1);
            if (i >= 2) begin
                check($sformatf("dir_valid%0d", i - 2), int'(out_valid), 1);
                check($sformatf("dir_k%0d", i - 2), int'(out_k), dir_k[i-2]);
                check($sformatf("dir_re%0d", i - 2), int'($signed(out_re)), re_tab[dir_k[i-2]]);
                check($sformatf("dir_im%0d", i - 2), int'($signed(out_im)), im_tab[dir_k[i-2]]);
            end
        end

        // Stage 1 sequence
        kick(1);
        check("s1_busy", int'(busy), 1);
        collect(8, 0);
        exp_k = '{0, 2, 4, 6, 0, 2, 4, 6};
        cmp_seq("s1", 8);
        check_done("s1");

        // Stage 3 sequence: every twiddle is W^0
        kick(3);
        collect(8, 0);
        exp_k = '{0, 0, 0, 0, 0, 0, 0, 0};
        cmp_seq("s3", 8);
        check_done("s3");

        // Out-of-range stage
        kick(4);
        @(negedge clk);
        check("s4_serr", int'(stage_err), 1);
        check("s4_busy", int'(busy), 0);
        @(negedge clk);
        check("s4_serr_pulse", int'(stage_err), 0);
        check("s4_valid", int'(out_valid), 0);
        check("s4_busy2", int'(busy), 0);

        // Stage 0 under backpressure
        kick(0);
        collect(8, 1);
        out_ready = 1'b1;
        exp_k = '{0, 1, 2, 3, 4, 5, 6, 7};
        cmp_seq("s0bp", 8);
        check_done("s0bp");

        // Reset in the middle of a stage-0 run
        kick(0);
        collect(3, 0);
        cmp_seq("s0rst", 3);
        nd  = n_done;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", int'(out_valid), 0);
        check("rst_mid_busy", int'(busy), 0);
        repeat (4) @(negedge clk);
        check("rst_mid_nodone", n_done, nd);

        kick(0);
        collect(8, 0);
        cmp_seq("s0new", 8);
        check_done("s0new");

        // start and req_valid together: start wins, request waits for IDLE
        @(posedge clk);
        #1;
        start = 1'b1; stage = 3'd1; req_valid = 1'b1; req_k = 3'd5;
        #1;
        check("co_ready0", int'(req_ready), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("co_ready_run", int'(req_ready), 0);
        collect(8, 0);
        exp_k = '{0, 2, 4, 6, 0, 2, 4, 6};
        cmp_seq("co", 8);
        check("co_ready_idle", int'(req_ready), 1);
        @(negedge clk);
        check("co_done", int'(done), 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 10 && !found; t++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
        end
        check("co_req_seen", int'(found), 1);
        if (found) begin
            check("co_req_k", int'(out_k), 5);
            check("co_req_re", int'($signed(out_re)), -49);
            check("co_req_im", int'($signed(out_im)), -117);
        end

        repeat (3) @(negedge clk);
        check("total_done", n_done, 5);
        check("total_serr", n_serr, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
